trng_arbiter: RTL and testbench
===============================

# trng_arbiter

Sequencing and sharing controller for the 32-bit ring-oscillator TRNG word source (`random32`). It powers the entropy source up only on demand and enforces a warm-up period before any output is trusted. Accepted words pass a repetition-count health test and are distributed to up to `NREQ` consumers by round-robin. It also shuts the oscillators down after an idle timeout, and raises a sticky fault on health-test failure.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `WARMUP_CYCLES`, 64: cycles after `rng_en` rises during which all words are discarded (≥1)
- `IDLE_TIMEOUT`, 256: cycles with no request pending before oscillators are switched off (≥1)
- `REP_LIMIT`, 3: consecutive identical words that trigger fault (≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  level request per consumer; held until served
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: word delivered to that consumer
- `rsp_data`  out  32  delivered word; valid while any `rsp_valid` bit is high
- `rng_en`  out  1  enable to the TRNG word source
- `rng_word`  in  32  word from the source
- `rng_ready`  in  1  one-cycle pulse: `rng_word` is fresh
- `fault`  out  1  sticky health-test failure
- `fault_clr`  in  1  pulse: clear fault, return to OFF
- `active`  out  1  high whenever state ≠ OFF

## Operation
- Registered state machine with states OFF, WARMUP, RUN, FAULT.
- **OFF**
  - `rng_en`=0.
  - Any `req` bit high → WARMUP, with the warm-up counter loaded to `WARMUP_CYCLES`-1.
- **WARMUP**
  - `rng_en`=1; all `rng_ready` pulses are ignored.
  - Counter decrements each cycle; at 0 → RUN.
  - If `req` drops to all-zero, the state still proceeds to RUN, and the idle timer handles shutdown.
- **RUN**
  - `rng_en`=1. The block has a single 32-bit buffer with a `buf_valid` flag.
  - **Health test** on each `rng_ready`:
    - If `rng_word` equals `last_word`, the word is dropped and `rep_cnt` increments.
    - If `rep_cnt`+1 reaches `REP_LIMIT`-1 (i.e. `REP_LIMIT` identical consecutive words), → FAULT.
    - Otherwise `rep_cnt`←0, `last_word`←`rng_word`, and the word is accepted.
    - `last_word` is valid only after the first accepted word since entering RUN; the first word is always accepted.
  - **Delivery** each edge where a word is available (`buf_valid`, or an accepted word on this edge when the buffer is empty) and any `req` is high:
    - Grant the first `req` index at or after the round-robin pointer `rr`, cyclically.
    - Register `rsp_valid[g]`=1 and `rsp_data`=word.
    - Set `rr`←(g+1) mod `NREQ`.
  - **Simultaneous events:** if `buf_valid` and an accepted word arrive on the same edge as a delivery, the buffer content is delivered and the new word loads the buffer.
  - **Buffer full with no request:** a newly accepted word overwrites the buffer (freshest word kept).
  - **Idle timer:** counts cycles with `req`==0 and resets whenever any `req` is high. Reaching `IDLE_TIMEOUT` → OFF; this clears `buf_valid`, `rep_cnt` and the `last_word` validity.
- **FAULT**
  - `rng_en`=0, `fault`=1, `buf_valid` cleared; no deliveries.
  - `fault_clr` → OFF with `fault`=0. `fault_clr` in any other state is ignored.
- **Consumer protocol:** a consumer that needs one word deasserts `req` in the cycle it sees its `rsp_valid`. A `req` held high receives further words in round-robin turn.

## Timing
- **Reset values** (asynchronous): state OFF, `rng_en`=0, `rsp_valid`=0, `rsp_data`=0, `fault`=0, `active`=0, `rr`=0, `buf_valid`=0, `rep_cnt`=0, both counters 0. `rng_en` falls immediately on `rst`, not at the next edge.
- **Power-up:** `req` is seen high at edge E0 in OFF → `rng_en`=1 from E0. RUN is entered at edge E0+`WARMUP_CYCLES`.
- **Delivery latency:**
  - A word with `rng_ready` high at edge E, with a request pending, gives `rsp_valid` high in the cycle after E, for exactly one cycle.
  - A buffered word is delivered in the cycle after the first edge at which `req` is seen high.
- `rsp_valid` is never asserted outside RUN and never has more than one bit set.
- A `req` bit deasserted before the grant edge is not served.
- **Reset mid-operation** (any state): the buffer is lost, and no `rsp_valid` is emitted after `rst` is asserted.

## Test plan
- **Power-up:** reset, then `req`=4'b0100. `rng_en` rises the next cycle. A `rng_ready` with 0xAAAA0000 during WARMUP is ignored. After 64 cycles, `rng_ready` with 0xDEADBEEF → `rsp_valid`=4'b0100 and `rsp_data`=0xDEADBEEF one cycle later, for one cycle.
- **Round-robin:** `req`=4'b1111 held, distinct words W0..W4 → grants to 0,1,2,3,0 in that order.
- **Buffer and idle:** word 0x0BADF00D arrives with `req`=0, then `req`[1] is asserted 10 cycles later → `rsp_valid`=4'b0010 with 0x0BADF00D one cycle after. With `req`=0 thereafter, after 256 cycles `rng_en`=0 and `active`=0.
- **Health fault:** 0x12345678 is delivered three times consecutively in RUN (`REP_LIMIT`=3). The 2nd is dropped with no `rsp_valid`; the 3rd → `fault`=1 and `rng_en`=0. `fault_clr` → `fault`=0, state OFF.
- **Async reset:** assert `rst` mid-WARMUP and again mid-RUN with the buffer full → `rng_en`=0 and `rsp_valid`=0 immediately; no delivery after deassertion until a new warm-up completes.
- **Simultaneous events:** buffer holds A, new word B is accepted on the same edge as `req`[3] rises → `rsp_data`=A to consumer 3, and B remains buffered for the next request.

Source files
------------

// File: rtl/trng_arbiter.sv
// Sequencer and round-robin distributor for a 32-bit ring-oscillator TRNG word source.
// Handles on-demand power-up, warm-up discard, repetition-count health test and idle shutdown.
module trng_arbiter #(
  parameter int NREQ          = 4,
  parameter int WARMUP_CYCLES = 64,
  parameter int IDLE_TIMEOUT  = 256,
  parameter int REP_LIMIT     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] rsp_valid,
  output logic [31:0]     rsp_data,
  output logic            rng_en,
  input  logic [31:0]     rng_word,
  input  logic            rng_ready,
  output logic            fault,
  input  logic            fault_clr,
  output logic            active
);

  localparam int RRW = (NREQ > 1)          ? $clog2(NREQ)          : 1;
  localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int ICW = (IDLE_TIMEOUT > 1)  ? $clog2(IDLE_TIMEOUT)  : 1;
  localparam int RCW = (REP_LIMIT > 1)     ? $clog2(REP_LIMIT)     : 1;

  localparam logic [WCW-1:0] WARM_LOAD = WCW'(WARMUP_CYCLES - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TIMEOUT - 1);
  localparam logic [RCW-1:0] REP_TRIP  = RCW'(REP_LIMIT - 1);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  logic [1:0]      state_r,  state_s;
  logic [WCW-1:0]  wcnt_r,   wcnt_s;
  logic [ICW-1:0]  idle_r,   idle_s;
  logic [RCW-1:0]  rep_r,    rep_s;
  logic [31:0]     last_r,   last_s;
  logic            lv_r,     lv_s;
  logic [31:0]     buf_r,    buf_s;
  logic            bv_r,     bv_s;
  logic [RRW-1:0]  rr_r,     rr_s;

  logic            any_req_s;
  logic            trip_s;
  logic            accept_s;
  logic            deliver_s;
  logic            grant_found_s;
  logic [RRW-1:0]  grant_s;
  logic [NREQ-1:0] grant_hot_s;
  logic [31:0]     word_s;

  function automatic logic [RRW-1:0] rr_wrap(input logic [RRW-1:0] base, input int offs);
    int sum_v;
    sum_v = int'(base) + offs;
    if (sum_v >= NREQ) begin
      sum_v = sum_v - NREQ;
    end else begin
      sum_v = sum_v;
    end
    return sum_v[RRW-1:0];
  endfunction

  assign any_req_s = |req;

  // Repetition-count health test on each fresh word while running
  always_comb begin
    trip_s   = 1'b0;
    accept_s = 1'b0;
    if ((state_r == ST_RUN) && rng_ready) begin
      if (lv_r && (rng_word == last_r)) begin
        trip_s = ((rep_r + RCW'(1)) == REP_TRIP);
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Round-robin search starting at the pointer, wrapping cyclically
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found_s && req[rr_wrap(rr_r, k)]) begin
        grant_found_s = 1'b1;
        grant_s       = rr_wrap(rr_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // The buffered word always goes out ahead of a word arriving on the same edge
  assign word_s    = bv_r ? buf_r : rng_word;
  assign deliver_s = (state_r == ST_RUN) && !trip_s && grant_found_s && (bv_r || accept_s);

  // One-hot grant vector for the registered response
  always_comb begin
    grant_hot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_hot_s[i] = deliver_s && (grant_s == RRW'(i));
    end
  end

  // Next-state, buffer, health-test and timer updates
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    idle_s  = idle_r;
    rep_s   = rep_r;
    last_s  = last_r;
    lv_s    = lv_r;
    buf_s   = buf_r;
    bv_s    = bv_r;
    rr_s    = rr_r;
    case (state_r)
      ST_OFF: begin
        idle_s = '0;
        rep_s  = '0;
        lv_s   = 1'b0;
        bv_s   = 1'b0;
        if (any_req_s) begin
          state_s = ST_WARMUP;
          wcnt_s  = WARM_LOAD;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_WARMUP: begin
        if (wcnt_r == '0) begin
          state_s = ST_RUN;
          idle_s  = '0;
        end else begin
          wcnt_s = wcnt_r - WCW'(1);
        end
      end
      ST_RUN: begin
        if (trip_s) begin
          state_s = ST_FAULT;
          bv_s    = 1'b0;
          rep_s   = '0;
          lv_s    = 1'b0;
        end else begin
          if (rng_ready && !accept_s) begin
            rep_s = rep_r + RCW'(1);
          end else if (accept_s) begin
            rep_s  = '0;
            last_s = rng_word;
            lv_s   = 1'b1;
          end else begin
            rep_s = rep_r;
          end

          if (deliver_s) begin
            rr_s = rr_wrap(grant_s, 1);
            if (bv_r && accept_s) begin
              buf_s = rng_word;
            end else if (bv_r) begin
              bv_s = 1'b0;
            end else begin
              bv_s = 1'b0;
            end
          end else if (accept_s) begin
            buf_s = rng_word;
            bv_s  = 1'b1;
          end else begin
            bv_s = bv_r;
          end

          if (any_req_s) begin
            idle_s = '0;
          end else if (idle_r == IDLE_LAST) begin
            state_s = ST_OFF;
            idle_s  = '0;
            bv_s    = 1'b0;
            rep_s   = '0;
            lv_s    = 1'b0;
          end else begin
            idle_s = idle_r + ICW'(1);
          end
        end
      end
      ST_FAULT: begin
        bv_s = 1'b0;
        if (fault_clr) begin
          state_s = ST_OFF;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_OFF;
        bv_s    = 1'b0;
        lv_s    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_OFF;
      wcnt_r    <= '0;
      idle_r    <= '0;
      rep_r     <= '0;
      last_r    <= '0;
      lv_r      <= 1'b0;
      buf_r     <= '0;
      bv_r      <= 1'b0;
      rr_r      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rng_en    <= 1'b0;
      fault     <= 1'b0;
      active    <= 1'b0;
    end else begin
      state_r   <= state_s;
      wcnt_r    <= wcnt_s;
      idle_r    <= idle_s;
      rep_r     <= rep_s;
      last_r    <= last_s;
      lv_r      <= lv_s;
      buf_r     <= buf_s;
      bv_r      <= bv_s;
      rr_r      <= rr_s;
      rsp_valid <= grant_hot_s;
      if (deliver_s) begin
        rsp_data <= word_s;
      end else begin
        rsp_data <= rsp_data;
      end
      rng_en    <= (state_s == ST_WARMUP) || (state_s == ST_RUN);
      fault     <= (state_s == ST_FAULT);
      active    <= (state_s != ST_OFF);
    end
  end

endmodule

// File: tb/tb_trng_arbiter.sv
// Scoreboard bench for trng_arbiter: expected responses are queued as stimulus is driven
// and compared by a monitor whenever the DUT raises rsp_valid.
module tb_trng_arbiter;

  localparam int NREQ   = 4;
  localparam int WARMUP = 64;
  localparam int IDLE   = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rsp_valid;
  logic [31:0]     rsp_data;
  logic            rng_en;
  logic [31:0]     rng_word;
  logic            rng_ready;
  logic            fault;
  logic            fault_clr;
  logic            active;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [35:0] sb_q[$];

  trng_arbiter #(
    .NREQ(NREQ), .WARMUP_CYCLES(WARMUP), .IDLE_TIMEOUT(IDLE), .REP_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rng_en(rng_en), .rng_word(rng_word), .rng_ready(rng_ready), .fault(fault),
    .fault_clr(fault_clr), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_word(input logic [31:0] w);
    rng_word  = w;
    rng_ready = 1'b1;
    @(negedge clk);
    rng_ready = 1'b0;
  endtask

  task automatic expect_rsp(input logic [3:0] v, input logic [31:0] d);
    sb_q.push_back({v, d});
  endtask

  // From OFF: raise req, confirm power-up, then wait until RUN has been entered
  task automatic bring_up(input logic [3:0] r);
    req = r;
    tick(1);
    chk("rng_en_rise", 64'(rng_en), 64'd1);
    tick(WARMUP);
  endtask

  // Monitor: every response must match the oldest queued expectation
  always @(negedge clk) begin
    if (rsp_valid !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
      end else begin
        chk("rsp", 64'({rsp_valid, rsp_data}), 64'(sb_q.pop_front()));
      end
      chk("rsp_only_powered", 64'(rng_en), 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [5];
    logic [3:0]  rr_exp[5];
    words  = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004, 32'h5000_0005};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; req = 4'b0000; rng_word = 32'd0; rng_ready = 1'b0; fault_clr = 1'b0;
    tick(2);
    chk("rst_rng_en", 64'(rng_en), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    rst = 1'b0;
    tick(1);

    // Power-up and warm-up discard
    req = 4'b0100;
    tick(1);
    chk("pu_rng_en", 64'(rng_en), 64'd1);
    chk("pu_active", 64'(active), 64'd1);
    pulse_word(32'hAAAA_0000);
    tick(62);
    pulse_word(32'h1111_1111);
    expect_rsp(4'b0100, 32'hDEAD_BEEF);
    pulse_word(32'hDEAD_BEEF);
    chk("pu_rsp_valid", 64'(rsp_valid), 64'h4);
    req = 4'b0000;
    tick(1);
    chk("pu_rsp_one_cycle", 64'(rsp_valid), 64'd0);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bring_up(4'b1111);
    for (int i = 0; i < 5; i++) begin
      expect_rsp(rr_exp[i], words[i]);
      pulse_word(words[i]);
    end
    req = 4'b0000;

    // Buffered word, late request, then idle shutdown
    pulse_word(32'h0BAD_F00D);
    tick(10);
    req = 4'b0010;
    expect_rsp(4'b0010, 32'h0BAD_F00D);
    tick(1);
    req = 4'b0000;
    tick(250);
    chk("idle_still_on", 64'(rng_en), 64'd1);
    tick(10);
    chk("idle_rng_en", 64'(rng_en), 64'd0);
    chk("idle_active", 64'(active), 64'd0);

    // Health fault on three identical words
    bring_up(4'b0001);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_ignored_run", 64'(active), 64'd1);
    expect_rsp(4'b0001, 32'h1234_5678);
    pulse_word(32'h1234_5678);
    pulse_word(32'h1234_5678);
    chk("rep2_no_fault", 64'(fault), 64'd0);
    pulse_word(32'h1234_5678);
    chk("rep3_fault", 64'(fault), 64'd1);
    chk("rep3_rng_en", 64'(rng_en), 64'd0);
    req = 4'b0000;
    tick(3);
    chk("fault_sticky", 64'(fault), 64'd1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    chk("clr_fault", 64'(fault), 64'd0);
    chk("clr_active", 64'(active), 64'd0);

    // Async reset during warm-up
    req = 4'b0001;
    tick(10);
    #2 rst = 1'b1;
    #1 chk("rst_warm_rng_en", 64'(rng_en), 64'd0);
    chk("rst_warm_active", 64'(active), 64'd0);
    @(negedge clk) rst = 1'b0;
    bring_up(4'b0001);

    // Async reset while a response is on the bus
    expect_rsp(4'b0001, 32'hC0FF_EE01);
    pulse_word(32'hC0FF_EE01);
    #2 rst = 1'b1;
    #1 chk("rst_rsp_valid_now", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rng_en", 64'(rng_en), 64'd0);
    req = 4'b0000;
    @(negedge clk) rst = 1'b0;

    // Async reset with the buffer full: the word is lost
    bring_up(4'b1000);
    req = 4'b0000;
    pulse_word(32'hA5A5_0000);
    #2 rst = 1'b1;
    #1 chk("rst_run_rng_en", 64'(rng_en), 64'd0);
    @(negedge clk) rst = 1'b0;
    req = 4'b1000;
    tick(WARMUP + 5);
    chk("lost_buf_no_rsp", 64'(rsp_valid), 64'd0);

    // Overwrite of an unrequested buffer, then simultaneous delivery and refill
    req = 4'b0000;
    pulse_word(32'hA0A0_A0A0);
    pulse_word(32'hA1A1_A1A1);
    req = 4'b1000;
    rng_word = 32'hB2B2_B2B2;
    rng_ready = 1'b1;
    expect_rsp(4'b1000, 32'hA1A1_A1A1);
    @(negedge clk);
    rng_ready = 1'b0;
    req = 4'b0000;
    tick(3);
    req = 4'b0100;
    expect_rsp(4'b0100, 32'hB2B2_B2B2);
    tick(1);
    req = 4'b0000;
    tick(3);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
